corevx_store_queue: RTL

- Buffers core stores between execute and the data-memory write port.
- Each accepted store is converted to bus form on entry:
  - word-aligned address
  - data shifted by byte lane
  - byte mask
  - misalignment and unknown-type checks
- Legal stores are queued in a DEPTH-entry FIFO and drained in order over a valid/ready write channel.
- Provides fence/drain status to the pipeline control.

---
 rtl/corevx_store_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/corevx_store_queue.sv
// Purpose : store queue between execute and the data-memory write port; converts stores to bus form on entry.
// Latency : a push at edge N is presented on m_* after edge N; a rejected store pulses err_valid the next cycle.
// Backpr. : s_ready = !full && !fence_req (a merge hit may also accept when full); m_* held while m_valid && !m_ready.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_valid/s_ready/s_addr/s_type/s_data  store request (type 0 byte, 1 half, 2 word, 3 illegal)
//   err_valid/err_cause               one-cycle reject pulse (1 misaligned, 2 unknown type)
//   m_valid/m_ready/m_addr/m_wdata/m_wmask  head entry on the write channel
//   fence_req/fence_done              drain request / queue empty with no push this cycle
//   count                             current occupancy
// Optional feature: define COREVX_STORE_QUEUE_MERGE_EN to merge same-word stores into the tail entry.
module corevx_store_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_addr,
    input  logic [1:0]       s_type,
    input  logic [31:0]      s_data,
    output logic             err_valid,
    output logic [1:0]       err_cause,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wmask,
    input  logic             fence_req,
    output logic             fence_done,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_addr_q [DEPTH];
    logic [31:0]      mem_addr_d [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [31:0]      mem_data_d [DEPTH];
    logic [3:0]       mem_mask_q [DEPTH];
    logic [3:0]       mem_mask_d [DEPTH];
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_cause_q, err_cause_d;

    // Request decode into bus form
    logic [1:0]  off;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic        req_bad_type;
    logic        req_misalign;
    logic        req_legal;

    always_comb begin
        off          = s_addr[1:0];
        req_addr     = {s_addr[31:2], 2'b00};
        req_data     = s_data << {off, 3'b000};
        req_bad_type = (s_type == 2'd3);
        req_mask     = 4'b0000;
        req_misalign = 1'b0;
        case (s_type)
            2'd0: req_mask = 4'b0001 << off;
            2'd1: begin
                req_mask     = 4'b0011 << off;
                req_misalign = off[0];
            end
            2'd2: begin
                req_mask     = 4'b1111;
                req_misalign = (off != 2'd0);
            end
            default: ;
        endcase
        req_legal = !req_bad_type && !req_misalign;
    end

    logic merge_hit;
`ifdef COREVX_STORE_QUEUE_MERGE_EN
    // With two or more entries the tail is never the presented head, so it may be edited freely.
    logic [PTR_W-1:0] tail_ptr;
    assign tail_ptr  = wr_ptr_q - PTR_W'(1);
    assign merge_hit = req_legal && (count_q >= CNT_W'(2)) && (mem_addr_q[tail_ptr] == req_addr);
`else
    assign merge_hit = 1'b0;
`endif

    logic full, accept, push, pop;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign s_ready = (!full || merge_hit) && !fence_req;
    assign accept  = s_valid && s_ready;
    // A merge hit is consumed without allocating; rejected stores are consumed and dropped.
    assign push    = accept && req_legal && !merge_hit;
    assign pop     = m_valid && m_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_mask_d = mem_mask_q;

        if (push) begin
            mem_addr_d[wr_ptr_q] = req_addr;
            mem_data_d[wr_ptr_q] = req_data;
            mem_mask_d[wr_ptr_q] = req_mask;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
`ifdef COREVX_STORE_QUEUE_MERGE_EN
        if (accept && merge_hit) begin
            mem_mask_d[tail_ptr] = mem_mask_q[tail_ptr] | req_mask;
            for (int b = 0; b < 4; b++) begin
                if (req_mask[b]) begin
                    mem_data_d[tail_ptr][b*8 +: 8] = req_data[b*8 +: 8];
                end
            end
        end
`endif
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase

        err_valid_d = accept && !req_legal;
        err_cause_d = 2'd0;
        if (err_valid_d) begin
            err_cause_d = req_bad_type ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
                mem_mask_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_mask_q  <= mem_mask_d;
        end
    end

    assign m_valid    = (count_q != '0);
    assign m_addr     = mem_addr_q[rd_ptr_q];
    assign m_wdata    = mem_data_q[rd_ptr_q];
    assign m_wmask    = mem_mask_q[rd_ptr_q];
    assign count      = count_q;
    assign fence_done = (count_q == '0) && !accept;
    assign err_valid  = err_valid_q;
    assign err_cause  = err_cause_q;

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));

endmodule
